sa_mat_loader: RTL and testbench
================================

SA_MAT_LOADER -- requirements
Module: sa_mat_loader

Interface
REQ-001 Parameter D_W, default 8: element width in bits.
REQ-002 Parameter X_R, default 16: X matrix rows.
REQ-003 Parameter W_C, default 16: W matrix columns.
REQ-004 Parameter MAX_DIM, default 128: maximum inner dimension.
REQ-005 Ports SHALL be:
- I_CLK  in  1  single clock; all logic is on its rising edge.
- I_RSTN  in  1  synchronous, active-low reset.
- I_CFG_VALID  in  1  configuration valid.
- I_M_DIM  in  8  inner dimension of the next job.
- O_CFG_READY  out  1  loader can accept a configuration.
- I_DATA_VALID  in  1  stream element valid.
- I_DATA  in  D_W  stream element.
- O_DATA_READY  out  1  loader can accept an element.
- O_X_MATRIX  out  D_W x [X_R][MAX_DIM]  X buffer to the matrix manager.
- O_W_MATRIX  out  D_W x [MAX_DIM][W_C]  W buffer to the matrix manager.
- O_M_DIM  out  8  latched dimension to the matrix manager.
- O_START  out  1  one-cycle job start pulse to the matrix manager.
- I_OVER  in  1  matrix manager done flag.
- O_BUSY  out  1  job in progress.
- O_ERR  out  1  one-cycle pulse when a configuration is rejected.

Function
REQ-006 States SHALL be IDLE, LOAD_X, LOAD_W, START and WAIT_OVER.
REQ-007 O_CFG_READY SHALL be 1 only in IDLE; O_DATA_READY SHALL be 1 only in LOAD_X and LOAD_W.
REQ-008 A configuration handshake occurs when I_CFG_VALID & O_CFG_READY; a data handshake occurs when I_DATA_VALID & O_DATA_READY.
REQ-009 On a configuration handshake with 1 <= I_M_DIM <= MAX_DIM:
- latch O_M_DIM;
- clear both buffers to 0;
- reset the row and column counters;
- go to LOAD_X.
REQ-010 On a configuration handshake with I_M_DIM == 0 or I_M_DIM > MAX_DIM:
- pulse O_ERR for one cycle;
- stay in IDLE;
- leave buffers and O_M_DIM unchanged.
REQ-011 LOAD_X: each data handshake writes O_X_MATRIX[row][col] (row-major); col wraps at O_M_DIM-1 and row increments; go to LOAD_W after the write at row X_R-1, col O_M_DIM-1.
REQ-012 LOAD_W: each data handshake writes O_W_MATRIX[row][col] (row-major); col wraps at W_C-1; go to START after the write at row O_M_DIM-1, col W_C-1.
REQ-013 Counters SHALL hold while I_DATA_VALID is low; gaps of any length are legal.
REQ-014 Buffer entries with index >= O_M_DIM SHALL read 0 for the whole job.
REQ-015 START SHALL last exactly one cycle with O_START=1, then go to WAIT_OVER.
REQ-016 O_START SHALL occur exactly one cycle after the final element is accepted.
REQ-017 WAIT_OVER SHALL ignore I_OVER in its first cycle, to mask a stale done flag from the previous job.
REQ-018 From the second WAIT_OVER cycle on, I_OVER=1 SHALL return the block to IDLE on the next edge.
REQ-019 The first cycle of IDLE after a job SHALL assert O_CFG_READY.
REQ-020 O_X_MATRIX, O_W_MATRIX and O_M_DIM SHALL be stable from START until the next accepted configuration.
REQ-021 O_BUSY SHALL be 1 in every state except IDLE.
REQ-022 Total accepted elements per job SHALL be X_R*M + M*W_C, where M = O_M_DIM.
REQ-023 Row and column counters SHALL be 8 bits wide with no overflow for any legal M.

Reset
REQ-024 When I_RSTN=0 at a clock edge, the block SHALL enter IDLE and clear both buffers, O_M_DIM, the counters, O_START and O_ERR to 0, from any state including mid-load and WAIT_OVER.
REQ-025 Reset values SHALL be:
- O_CFG_READY=1 from the first cycle after reset release;
- O_DATA_READY=0, O_BUSY=0.

Structure
REQ-026 Package sa_pkg SHALL hold the state enum type and the MAX_DIM constant.
REQ-027 The wrapping row/column index pair SHALL be a sub-module, sa_idx_counter, instantiated once and reloaded with its wrap limit per state.

Verification
REQ-028 M=4, X_R=W_C=16, data 1..128 continuous -> X[0][0..3]=1..4, X[0][4]=0, W[0][0]=65, W[3][15]=128, O_START one cycle after the 128th handshake.
REQ-029 M=4 with I_DATA_VALID toggling 1/0 every cycle -> same buffer contents as REQ-028, O_START one cycle after the 128th handshake.
REQ-030 Configurations M=0 and M=200 -> O_ERR pulses once for each, O_CFG_READY stays 1, O_M_DIM is unchanged.
REQ-031 I_OVER held at 1 through START and the first WAIT_OVER cycle -> block does not return to IDLE until the second WAIT_OVER cycle.
REQ-032 I_RSTN low for one cycle at element 70 of an M=4 job -> IDLE, all buffers 0, O_CFG_READY=1 on the next cycle, and a fresh job completes correctly.
REQ-033 M=128 -> 4096 handshakes, W[127][15] holds the last element, O_START fires exactly once.

Source files
------------

// File: rtl/sa_pkg.sv
`default_nettype none
//==============================================================================
// Package  : sa_pkg
// Brief    : Shared types and constants for the systolic-array matrix loader:
//            loader state encoding, default inner-dimension limit and an
//            index-width helper.
// Revision : 1.0 - initial release
//==============================================================================
package sa_pkg;

    // Largest inner dimension the loader buffers are sized for by default.
    localparam int SA_MAX_DIM = 128;

    // Loader sequencing states.
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LOAD_X    = 3'd1,
        ST_LOAD_W    = 3'd2,
        ST_START     = 3'd3,
        ST_WAIT_OVER = 3'd4
    } sa_state_e;

    // Bits needed to address an array of n entries (at least one bit).
    function automatic int idx_bits(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage : sa_pkg
`default_nettype wire

// File: rtl/sa_mat_loader_if.sv
`default_nettype none
//==============================================================================
// Interface : sa_mat_loader_if
// Brief     : Configuration handshake, element stream and matrix-manager
//             signals of the matrix loader. "master" is the loader side,
//             "slave" is the stream source / matrix manager side.
// Revision  : 1.0 - initial release
//==============================================================================
interface sa_mat_loader_if #(
    parameter int D_W     = 8,
    parameter int X_R     = 16,
    parameter int W_C     = 16,
    parameter int MAX_DIM = sa_pkg::SA_MAX_DIM
);
    // configuration channel
    logic             I_CFG_VALID;
    logic [7:0]       I_M_DIM;
    logic             O_CFG_READY;
    // element stream
    logic             I_DATA_VALID;
    logic [D_W-1:0]   I_DATA;
    logic             O_DATA_READY;
    // matrix manager side
    logic [D_W-1:0]   O_X_MATRIX [X_R][MAX_DIM];
    logic [D_W-1:0]   O_W_MATRIX [MAX_DIM][W_C];
    logic [7:0]       O_M_DIM;
    logic             O_START;
    logic             I_OVER;
    // status
    logic             O_BUSY;
    logic             O_ERR;

    modport master (
        input  I_CFG_VALID, I_M_DIM, I_DATA_VALID, I_DATA, I_OVER,
        output O_CFG_READY, O_DATA_READY, O_X_MATRIX, O_W_MATRIX,
               O_M_DIM, O_START, O_BUSY, O_ERR
    );

    modport slave (
        output I_CFG_VALID, I_M_DIM, I_DATA_VALID, I_DATA, I_OVER,
        input  O_CFG_READY, O_DATA_READY, O_X_MATRIX, O_W_MATRIX,
               O_M_DIM, O_START, O_BUSY, O_ERR
    );

endinterface : sa_mat_loader_if
`default_nettype wire

// File: rtl/sa_idx_counter.sv
`default_nettype none
//==============================================================================
// Module   : sa_idx_counter
// Brief    : Row/column index pair for row-major buffer filling. The column
//            wraps at a run-time limit and carries into the row.
// Revision : 1.0 - initial release
//==============================================================================
module sa_idx_counter (
    input  logic       clk,
    input  logic       i_rstn,
    input  logic       i_clr,      // restart at row 0, col 0
    input  logic       i_adv,      // step one element
    input  logic [7:0] i_col_max,  // last column index before wrapping
    output logic [7:0] o_row,
    output logic [7:0] o_col,
    output logic       o_col_wrap  // current column is the last one
);

    logic [7:0] r_row_q, w_row_d;
    logic [7:0] r_col_q, w_col_d;

    // Next index: clear has priority over advance; hold otherwise.
    always_comb begin
        w_row_d = r_row_q;
        w_col_d = r_col_q;
        if (i_clr) begin
            w_row_d = 8'd0;
            w_col_d = 8'd0;
        end else if (i_adv) begin
            if (r_col_q == i_col_max) begin
                w_col_d = 8'd0;
                w_row_d = r_row_q + 8'd1;
            end else begin
                w_col_d = r_col_q + 8'd1;
            end
        end
    end

    // Index registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!i_rstn) begin
            r_row_q <= 8'd0;
            r_col_q <= 8'd0;
        end else begin
            r_row_q <= w_row_d;
            r_col_q <= w_col_d;
        end
    end

    assign o_row      = r_row_q;
    assign o_col      = r_col_q;
    assign o_col_wrap = (r_col_q == i_col_max);

endmodule : sa_idx_counter
`default_nettype wire

// File: rtl/sa_mat_loader.sv
`default_nettype none
//==============================================================================
// Module   : sa_mat_loader
// Brief    : Accepts a job configuration (inner dimension M), streams X
//            (X_R x M) then W (M x W_C) elements into zero-padded buffers,
//            pulses start to the matrix manager and waits for its done flag.
// Revision : 1.0 - initial release
//==============================================================================
module sa_mat_loader
    import sa_pkg::*;
#(
    parameter int D_W     = 8,
    parameter int X_R     = 16,
    parameter int W_C     = 16,
    parameter int MAX_DIM = SA_MAX_DIM
) (
    input  logic              I_CLK,
    input  logic              I_RSTN,
    sa_mat_loader_if.master   bus
);

    localparam int C_XR_IW = idx_bits(X_R);
    localparam int C_MD_IW = idx_bits(MAX_DIM);
    localparam int C_WC_IW = idx_bits(W_C);

    // state and registered outputs
    sa_state_e      r_state_q, w_state_d;
    logic           r_cfg_ready_q, w_cfg_ready_d;
    logic           r_data_ready_q, w_data_ready_d;
    logic           r_busy_q, w_busy_d;
    logic           r_start_q, w_start_d;
    logic           r_err_q, w_err_d;
    logic           r_wait_first_q, w_wait_first_d;
    logic [7:0]     r_m_dim_q, w_m_dim_d;

    // operand buffers
    logic [D_W-1:0] r_x_q [X_R][MAX_DIM];
    logic [D_W-1:0] w_x_d [X_R][MAX_DIM];
    logic [D_W-1:0] r_w_q [MAX_DIM][W_C];
    logic [D_W-1:0] w_w_d [MAX_DIM][W_C];

    // handshakes and index control
    logic           w_cfg_hs;
    logic           w_cfg_ok;
    logic           w_data_hs;
    logic           w_idx_clr;
    logic [7:0]     w_col_max;
    logic [7:0]     w_row;
    logic [7:0]     w_col;
    logic           w_col_wrap;
    logic           w_x_last;
    logic           w_w_last;

    assign w_cfg_hs  = bus.I_CFG_VALID & r_cfg_ready_q;
    assign w_cfg_ok  = (bus.I_M_DIM != 8'd0) && (int'(bus.I_M_DIM) <= MAX_DIM);
    assign w_data_hs = bus.I_DATA_VALID & r_data_ready_q;

    // X rows are M wide, W rows are W_C wide; one counter serves both phases.
    assign w_col_max = (r_state_q == ST_LOAD_W) ? 8'(W_C - 1) : (r_m_dim_q - 8'd1);

    assign w_x_last = (r_state_q == ST_LOAD_X) && w_data_hs &&
                      (w_row == 8'(X_R - 1)) && w_col_wrap;
    assign w_w_last = (r_state_q == ST_LOAD_W) && w_data_hs &&
                      (w_row == (r_m_dim_q - 8'd1)) && w_col_wrap;

    // Restart indexing on a new job and again when switching from X to W.
    assign w_idx_clr = (w_cfg_hs && w_cfg_ok) || w_x_last;

    sa_idx_counter u_idx (
        .clk        (I_CLK),
        .i_rstn     (I_RSTN),
        .i_clr      (w_idx_clr),
        .i_adv      (w_data_hs),
        .i_col_max  (w_col_max),
        .o_row      (w_row),
        .o_col      (w_col),
        .o_col_wrap (w_col_wrap)
    );

    // Next state, dimension latch and buffer writes.
    always_comb begin
        w_state_d      = r_state_q;
        w_m_dim_d      = r_m_dim_q;
        w_err_d        = 1'b0;
        w_wait_first_d = 1'b0;
        w_x_d          = r_x_q;
        w_w_d          = r_w_q;

        case (r_state_q)
            ST_IDLE: begin
                if (w_cfg_hs) begin
                    if (w_cfg_ok) begin
                        // Clearing here keeps every entry beyond M at zero
                        // for the whole job.
                        w_m_dim_d = bus.I_M_DIM;
                        w_x_d     = '{default: '0};
                        w_w_d     = '{default: '0};
                        w_state_d = ST_LOAD_X;
                    end else begin
                        w_err_d = 1'b1;
                    end
                end
            end
            ST_LOAD_X: begin
                if (w_data_hs) begin
                    w_x_d[w_row[C_XR_IW-1:0]][w_col[C_MD_IW-1:0]] = bus.I_DATA;
                    if (w_x_last) begin
                        w_state_d = ST_LOAD_W;
                    end
                end
            end
            ST_LOAD_W: begin
                if (w_data_hs) begin
                    w_w_d[w_row[C_MD_IW-1:0]][w_col[C_WC_IW-1:0]] = bus.I_DATA;
                    if (w_w_last) begin
                        w_state_d = ST_START;
                    end
                end
            end
            ST_START: begin
                w_state_d      = ST_WAIT_OVER;
                w_wait_first_d = 1'b1;
            end
            ST_WAIT_OVER: begin
                // The done flag may still be high from the previous job
                // during the first cycle here, so it is only honoured later.
                if (!r_wait_first_q && bus.I_OVER) begin
                    w_state_d = ST_IDLE;
                end
            end
            default: begin
                w_state_d = ST_IDLE;
            end
        endcase
    end

    // Outputs are decoded from the next state so they register alongside it.
    always_comb begin
        w_cfg_ready_d  = (w_state_d == ST_IDLE);
        w_data_ready_d = (w_state_d == ST_LOAD_X) || (w_state_d == ST_LOAD_W);
        w_busy_d       = (w_state_d != ST_IDLE);
        w_start_d      = (w_state_d == ST_START);
    end

    // All loader state and outputs; reset from any state returns to idle.
    always_ff @(posedge I_CLK) begin
        if (!I_RSTN) begin
            r_state_q      <= ST_IDLE;
            r_cfg_ready_q  <= 1'b1;
            r_data_ready_q <= 1'b0;
            r_busy_q       <= 1'b0;
            r_start_q      <= 1'b0;
            r_err_q        <= 1'b0;
            r_wait_first_q <= 1'b0;
            r_m_dim_q      <= 8'd0;
            r_x_q          <= '{default: '0};
            r_w_q          <= '{default: '0};
        end else begin
            r_state_q      <= w_state_d;
            r_cfg_ready_q  <= w_cfg_ready_d;
            r_data_ready_q <= w_data_ready_d;
            r_busy_q       <= w_busy_d;
            r_start_q      <= w_start_d;
            r_err_q        <= w_err_d;
            r_wait_first_q <= w_wait_first_d;
            r_m_dim_q      <= w_m_dim_d;
            r_x_q          <= w_x_d;
            r_w_q          <= w_w_d;
        end
    end

    assign bus.O_CFG_READY  = r_cfg_ready_q;
    assign bus.O_DATA_READY = r_data_ready_q;
    assign bus.O_BUSY       = r_busy_q;
    assign bus.O_START      = r_start_q;
    assign bus.O_ERR        = r_err_q;
    assign bus.O_M_DIM      = r_m_dim_q;
    assign bus.O_X_MATRIX   = r_x_q;
    assign bus.O_W_MATRIX   = r_w_q;

endmodule : sa_mat_loader
`default_nettype wire

// File: tb/tb_sa_mat_loader.sv
`default_nettype none
//==============================================================================
// Module   : tb_sa_mat_loader
// Brief    : Directed self-checking bench for sa_mat_loader.
// Revision : 1.0 - initial release
//==============================================================================
module tb_sa_mat_loader;

    localparam int D_W     = 8;
    localparam int X_R     = 16;
    localparam int W_C     = 16;
    localparam int MAX_DIM = 128;

    logic clk = 1'b0;
    logic rstn;

    always #5 clk = ~clk;

    sa_mat_loader_if #(.D_W(D_W), .X_R(X_R), .W_C(W_C), .MAX_DIM(MAX_DIM)) bus ();

    sa_mat_loader #(.D_W(D_W), .X_R(X_R), .W_C(W_C), .MAX_DIM(MAX_DIM)) u_dut (
        .I_CLK  (clk),
        .I_RSTN (rstn),
        .bus    (bus)
    );

    int total     = 0;
    int bad       = 0;
    int start_cnt = 0;
    int s0;

    // Count start pulses seen at rising edges.
    always @(posedge clk) begin
        if (bus.O_START === 1'b1) start_cnt <= start_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_cfg(input logic [7:0] m);
        bus.I_CFG_VALID = 1'b1;
        bus.I_M_DIM     = m;
        tick();
        bus.I_CFG_VALID = 1'b0;
    endtask

    // One element; with gap set, valid is low for a cycle first.
    task automatic send(input logic [7:0] d, input bit gap);
        int n;
        if (gap) begin
            bus.I_DATA_VALID = 1'b0;
            tick();
        end
        bus.I_DATA_VALID = 1'b1;
        bus.I_DATA       = d;
        n = 0;
        while (bus.O_DATA_READY !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        if (n >= 50) chk("data_ready_timeout", {31'b0, bus.O_DATA_READY}, 32'd1);
        tick();
        bus.I_DATA_VALID = 1'b0;
    endtask

    // From START with I_OVER low: WAIT_OVER, then raise done and return to idle.
    task automatic finish_job(input string tag);
        tick();
        chk({tag, "_start_low"}, {31'b0, bus.O_START}, 32'd0);
        bus.I_OVER = 1'b1;
        tick();
        chk({tag, "_busy_wait"}, {31'b0, bus.O_BUSY}, 32'd1);
        tick();
        chk({tag, "_cfg_ready_idle"}, {31'b0, bus.O_CFG_READY}, 32'd1);
        chk({tag, "_busy_idle"}, {31'b0, bus.O_BUSY}, 32'd0);
        bus.I_OVER = 1'b0;
    endtask

    function automatic logic [7:0] f128(input int i);
        return 8'((i * 7 + 3) & 255);
    endfunction

    initial begin
        bus.I_CFG_VALID  = 1'b0;
        bus.I_M_DIM      = 8'd0;
        bus.I_DATA_VALID = 1'b0;
        bus.I_DATA       = '0;
        bus.I_OVER       = 1'b0;
        rstn             = 1'b0;
        repeat (2) tick();
        rstn = 1'b1;

        // reset state
        chk("rst_cfg_ready", {31'b0, bus.O_CFG_READY}, 32'd1);
        chk("rst_data_ready", {31'b0, bus.O_DATA_READY}, 32'd0);
        chk("rst_busy", {31'b0, bus.O_BUSY}, 32'd0);
        chk("rst_start", {31'b0, bus.O_START}, 32'd0);
        chk("rst_err", {31'b0, bus.O_ERR}, 32'd0);
        chk("rst_m_dim", {24'b0, bus.O_M_DIM}, 32'd0);
        chk("rst_x00", {24'b0, bus.O_X_MATRIX[0][0]}, 32'd0);

        // job A: M=4, continuous data 1..128
        do_cfg(8'd4);
        chk("a_m_dim", {24'b0, bus.O_M_DIM}, 32'd4);
        chk("a_data_ready", {31'b0, bus.O_DATA_READY}, 32'd1);
        chk("a_cfg_ready", {31'b0, bus.O_CFG_READY}, 32'd0);
        chk("a_busy", {31'b0, bus.O_BUSY}, 32'd1);
        s0 = start_cnt;
        for (int i = 1; i <= 127; i++) send(8'(i), 1'b0);
        chk("a_no_early_start", {31'b0, bus.O_START}, 32'd0);
        send(8'd128, 1'b0);
        chk("a_start", {31'b0, bus.O_START}, 32'd1);
        chk("a_x00", {24'b0, bus.O_X_MATRIX[0][0]}, 32'd1);
        chk("a_x01", {24'b0, bus.O_X_MATRIX[0][1]}, 32'd2);
        chk("a_x02", {24'b0, bus.O_X_MATRIX[0][2]}, 32'd3);
        chk("a_x03", {24'b0, bus.O_X_MATRIX[0][3]}, 32'd4);
        chk("a_x04", {24'b0, bus.O_X_MATRIX[0][4]}, 32'd0);
        chk("a_x10", {24'b0, bus.O_X_MATRIX[1][0]}, 32'd5);
        chk("a_x15_3", {24'b0, bus.O_X_MATRIX[15][3]}, 32'd64);
        chk("a_w00", {24'b0, bus.O_W_MATRIX[0][0]}, 32'd65);
        chk("a_w3_15", {24'b0, bus.O_W_MATRIX[3][15]}, 32'd128);
        chk("a_w40", {24'b0, bus.O_W_MATRIX[4][0]}, 32'd0);
        finish_job("a");
        chk("a_start_count", 32'(start_cnt - s0), 32'd1);

        // job B: M=4, valid toggling, done held high through START
        do_cfg(8'd4);
        s0 = start_cnt;
        for (int i = 1; i <= 127; i++) send(8'(i), 1'b1);
        bus.I_OVER = 1'b1;
        send(8'd128, 1'b1);
        chk("b_start", {31'b0, bus.O_START}, 32'd1);
        chk("b_x03", {24'b0, bus.O_X_MATRIX[0][3]}, 32'd4);
        chk("b_x04", {24'b0, bus.O_X_MATRIX[0][4]}, 32'd0);
        chk("b_w00", {24'b0, bus.O_W_MATRIX[0][0]}, 32'd65);
        chk("b_w3_15", {24'b0, bus.O_W_MATRIX[3][15]}, 32'd128);
        tick();
        chk("b_wait1_busy", {31'b0, bus.O_BUSY}, 32'd1);
        chk("b_wait1_start", {31'b0, bus.O_START}, 32'd0);
        tick();
        chk("b_wait2_busy", {31'b0, bus.O_BUSY}, 32'd1);
        chk("b_wait2_cfg_ready", {31'b0, bus.O_CFG_READY}, 32'd0);
        tick();
        chk("b_idle_cfg_ready", {31'b0, bus.O_CFG_READY}, 32'd1);
        chk("b_idle_busy", {31'b0, bus.O_BUSY}, 32'd0);
        bus.I_OVER = 1'b0;
        chk("b_start_count", 32'(start_cnt - s0), 32'd1);

        // rejected configurations
        do_cfg(8'd0);
        chk("e0_err", {31'b0, bus.O_ERR}, 32'd1);
        chk("e0_cfg_ready", {31'b0, bus.O_CFG_READY}, 32'd1);
        chk("e0_m_dim", {24'b0, bus.O_M_DIM}, 32'd4);
        chk("e0_busy", {31'b0, bus.O_BUSY}, 32'd0);
        tick();
        chk("e0_err_low", {31'b0, bus.O_ERR}, 32'd0);
        do_cfg(8'd200);
        chk("e200_err", {31'b0, bus.O_ERR}, 32'd1);
        chk("e200_cfg_ready", {31'b0, bus.O_CFG_READY}, 32'd1);
        chk("e200_m_dim", {24'b0, bus.O_M_DIM}, 32'd4);
        tick();
        chk("e200_err_low", {31'b0, bus.O_ERR}, 32'd0);
        do_cfg(8'd129);
        chk("e129_err", {31'b0, bus.O_ERR}, 32'd1);
        tick();
        chk("e_x00_kept", {24'b0, bus.O_X_MATRIX[0][0]}, 32'd1);
        chk("e_w3_15_kept", {24'b0, bus.O_W_MATRIX[3][15]}, 32'd128);

        // reset in the middle of a job, at element 70
        do_cfg(8'd4);
        for (int i = 1; i <= 69; i++) send(8'(i), 1'b0);
        bus.I_DATA_VALID = 1'b1;
        bus.I_DATA       = 8'd70;
        rstn             = 1'b0;
        tick();
        rstn             = 1'b1;
        bus.I_DATA_VALID = 1'b0;
        chk("r_cfg_ready", {31'b0, bus.O_CFG_READY}, 32'd1);
        chk("r_data_ready", {31'b0, bus.O_DATA_READY}, 32'd0);
        chk("r_busy", {31'b0, bus.O_BUSY}, 32'd0);
        chk("r_m_dim", {24'b0, bus.O_M_DIM}, 32'd0);
        chk("r_x00", {24'b0, bus.O_X_MATRIX[0][0]}, 32'd0);
        chk("r_x15_3", {24'b0, bus.O_X_MATRIX[15][3]}, 32'd0);
        chk("r_w00", {24'b0, bus.O_W_MATRIX[0][0]}, 32'd0);
        do_cfg(8'd4);
        s0 = start_cnt;
        for (int i = 1; i <= 128; i++) send(8'(i), 1'b0);
        chk("r2_start", {31'b0, bus.O_START}, 32'd1);
        chk("r2_x02", {24'b0, bus.O_X_MATRIX[0][2]}, 32'd3);
        chk("r2_w00", {24'b0, bus.O_W_MATRIX[0][0]}, 32'd65);
        chk("r2_w3_15", {24'b0, bus.O_W_MATRIX[3][15]}, 32'd128);
        finish_job("r2");
        chk("r2_start_count", 32'(start_cnt - s0), 32'd1);

        // job D: maximum dimension, 4096 elements
        do_cfg(8'd128);
        chk("d_m_dim", {24'b0, bus.O_M_DIM}, 32'd128);
        s0 = start_cnt;
        for (int i = 1; i <= 4095; i++) send(f128(i), 1'b0);
        chk("d_data_ready_before_last", {31'b0, bus.O_DATA_READY}, 32'd1);
        send(f128(4096), 1'b0);
        chk("d_start", {31'b0, bus.O_START}, 32'd1);
        chk("d_x00", {24'b0, bus.O_X_MATRIX[0][0]}, 32'd10);
        chk("d_x7_64", {24'b0, bus.O_X_MATRIX[7][64]}, 32'd74);
        chk("d_x15_127", {24'b0, bus.O_X_MATRIX[15][127]}, 32'd3);
        chk("d_w00", {24'b0, bus.O_W_MATRIX[0][0]}, 32'd10);
        chk("d_w127_15", {24'b0, bus.O_W_MATRIX[127][15]}, 32'd3);
        finish_job("d");
        chk("d_start_count", 32'(start_cnt - s0), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_sa_mat_loader
`default_nettype wire
